// File: rtl/spi_master_xchg_if.sv
// Word stream between a control client and spi_master_xchg: tx words in, rx words out.
// Latency: none, wiring only. Backpressure: tx uses valid/ready; rx has none (rx_valid is a 1-cycle pulse).
interface spi_master_xchg_if #(
    parameter int WORD_W = 16
);
    logic              tx_valid;
    logic              tx_ready;
    logic [WORD_W-1:0] tx_data;
    logic              tx_last;
    logic              rx_valid;
    logic [WORD_W-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/spi_master_xchg.sv
// Full-duplex SPI master: one WORD_W exchange per accepted word, CS held low across a burst until tx_last.
// Latency: rx word 2*WORD_W+2 half-periods after first accept (+2 clk with SYNC_MISO). Backpressure: tx_ready only in IDLE/GAP.
module spi_master_xchg #(
    parameter  int WORD_W    = 16,
    parameter  int DIV_W     = 8,
    parameter  int NCS       = 1,
    parameter  int SYNC_MISO = 1,
    localparam int CS_W      = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic               cfg_cpol,
    input  logic               cfg_cpha,
    input  logic               cfg_lsb_first,
    input  logic [CS_W-1:0]    cfg_cs_sel,
    spi_master_xchg_if.slave   xfer,
    output logic               busy,
    output logic               sck,
    output logic               mosi,
    input  logic               miso,
    output logic [NCS-1:0]     cs_n
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DESEL = 3'd5;

    localparam int             EW        = $clog2(2 * WORD_W);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * WORD_W - 1);

    logic [2:0]        state;
    logic [DIV_W-1:0]  tcnt;
    logic [DIV_W-1:0]  div_q;
    logic [EW-1:0]     edge_cnt;
    logic              cpha_q;
    logic              lsb_q;
    logic              last_q;
    logic              init_done;
    logic [WORD_W-1:0] tx_sh;
    logic [WORD_W-1:0] rx_sh;
    logic              rx_pend;

    logic              tick;
    logic              timing;
    logic              edge_now;
    logic              final_edge;
    logic              drive_edge;
    logic              sample_edge;
    logic              sample_fin;
    logic              accept;
    logic              cpha_eff;
    logic              lsb_eff;
    logic [NCS-1:0]    cs_sel_n;
    logic              samp_v;
    logic              samp_bit;
    logic              samp_fin;

    function automatic logic head_bit(input logic [WORD_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[WORD_W-1];
    endfunction

    function automatic logic [WORD_W-1:0] shift_out(input logic [WORD_W-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    assign xfer.tx_ready = (state == S_IDLE && init_done) || state == S_GAP;
    assign busy          = (state != S_IDLE);
    assign accept        = xfer.tx_valid && xfer.tx_ready;

    // Config is taken live on the accept from IDLE, from the latched copy afterwards.
    assign cpha_eff = (state == S_IDLE) ? cfg_cpha      : cpha_q;
    assign lsb_eff  = (state == S_IDLE) ? cfg_lsb_first : lsb_q;

    assign tick        = (tcnt == div_q);
    assign timing      = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD) || (state == S_DESEL);
    assign edge_now    = ((state == S_SETUP) || (state == S_XFER)) && tick;
    assign final_edge  = (edge_cnt == LAST_EDGE);
    assign sample_edge = edge_now && (edge_cnt[0] == cpha_q);
    // Last sample is edge 2W-2 (CPHA0) or 2W-1 (CPHA1); both share the upper bits.
    assign sample_fin  = sample_edge && (edge_cnt[EW-1:1] == LAST_EDGE[EW-1:1]);
    assign drive_edge  = edge_now && (cpha_q ? !edge_cnt[0] : (edge_cnt[0] && !final_edge));

    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NCS; i++) begin
            cs_sel_n[i] = (cfg_cs_sel != CS_W'(i));
        end
    end

    generate
        if (SYNC_MISO != 0) begin : g_sync
            logic [1:0] miso_sync;
            logic [1:0] sv_pipe;
            logic [1:0] sf_pipe;
            // Strobe travels alongside miso so the bit used is the one present at the sample edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    miso_sync <= '0;
                    sv_pipe   <= '0;
                    sf_pipe   <= '0;
                end else begin
                    miso_sync <= {miso_sync[0], miso};
                    sv_pipe   <= {sv_pipe[0], sample_edge};
                    sf_pipe   <= {sf_pipe[0], sample_fin};
                end
            end
            assign samp_v   = sv_pipe[1];
            assign samp_bit = miso_sync[1];
            assign samp_fin = sf_pipe[1];
        end else begin : g_raw
            assign samp_v   = sample_edge;
            assign samp_bit = miso;
            assign samp_fin = sample_fin;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            div_q     <= '0;
            edge_cnt  <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            last_q    <= 1'b0;
            init_done <= 1'b0;
            tx_sh     <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
        end else begin
            init_done <= 1'b1;
            tcnt      <= (tick || !timing) ? '0 : tcnt + 1'b1;

            if (accept) begin
                tx_sh    <= cpha_eff ? xfer.tx_data : shift_out(xfer.tx_data, lsb_eff);
                last_q   <= xfer.tx_last;
                edge_cnt <= '0;
                if (!cpha_eff) mosi <= head_bit(xfer.tx_data, lsb_eff);
            end

            if (drive_edge) begin
                mosi  <= head_bit(tx_sh, lsb_q);
                tx_sh <= shift_out(tx_sh, lsb_q);
            end

            if (edge_now) begin
                sck      <= ~sck;
                edge_cnt <= edge_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    sck <= cfg_cpol;
                    if (accept) begin
                        div_q  <= cfg_div;
                        cpha_q <= cfg_cpha;
                        lsb_q  <= cfg_lsb_first;
                        cs_n   <= cs_sel_n;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP, S_XFER: begin
                    if (edge_now) state <= final_edge ? (last_q ? S_HOLD : S_GAP) : S_XFER;
                end
                S_GAP: begin
                    if (accept) state <= S_XFER;
                end
                S_HOLD: begin
                    if (tick) begin
                        cs_n  <= '1;
                        state <= S_DESEL;
                    end
                end
                S_DESEL: begin
                    if (tick) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh         <= '0;
            rx_pend       <= 1'b0;
            xfer.rx_valid <= 1'b0;
            xfer.rx_data  <= '0;
        end else begin
            rx_pend       <= samp_fin;
            xfer.rx_valid <= rx_pend;
            if (samp_v) rx_sh <= lsb_q ? {samp_bit, rx_sh[WORD_W-1:1]} : {rx_sh[WORD_W-2:0], samp_bit};
            if (rx_pend) xfer.rx_data <= rx_sh;
        end
    end

endmodule

// File: tb/tb_spi_master_xchg.sv
// Directed bench for spi_master_xchg (WORD_W=16, NCS=4, raw miso) against a behavioural SPI slave on cs_n[2].
module tb_spi_master_xchg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] cfg_div = 8'd1;
    logic       cfg_cpol = 1'b1;
    logic       cfg_cpha = 1'b0;
    logic       cfg_lsb_first = 1'b0;
    logic [1:0] cfg_cs_sel = 2'd2;
    logic       busy, sck, mosi, miso;
    logic [3:0] cs_n;
    logic       loopback = 1'b1;

    spi_master_xchg_if #(.WORD_W(16)) bus ();

    spi_master_xchg #(.WORD_W(16), .DIV_W(8), .NCS(4), .SYNC_MISO(0)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb_first), .cfg_cs_sel(cfg_cs_sel), .xfer(bus), .busy(busy),
        .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: returns slv_tx MSB-first, logs received words MSB-first.
    logic [15:0] slv_tx = 16'h1234;
    logic [15:0] slv_sh = '0;
    logic        slv_miso = 1'b0;
    logic [3:0]  slv_bi = '0;
    int          slv_bits = 0;
    int          slv_cnt = 0;
    logic [15:0] slv_log [64];
    logic        cs_p = 1'b1;
    logic        sck_p = 1'b0;

    assign miso = loopback ? mosi : slv_miso;

    always @(sck or cs_n[2]) begin
        if (!cs_n[2] && cs_p) begin
            slv_bits = 0;
            slv_bi   = 4'd0;
            if (!cfg_cpha) begin
                slv_miso = slv_tx[15];
                slv_bi   = 4'd1;
            end
        end else if (!cs_n[2] && sck !== sck_p) begin
            if ((sck != cfg_cpol) ^ cfg_cpha) begin
                slv_sh = {slv_sh[14:0], mosi};
                slv_bits++;
                if (slv_bits == 16) begin
                    slv_log[slv_cnt % 64] = slv_sh;
                    slv_cnt++;
                    slv_bits = 0;
                end
            end else begin
                slv_miso = slv_tx[4'd15 - slv_bi];
                slv_bi   = slv_bi + 4'd1;
            end
        end
        cs_p  = cs_n[2];
        sck_p = sck;
    end

    // Passive monitor: counters only ever increase; the stimulus block takes differences.
    int          cyc = 0, sck_tog = 0, sck_cyc = 0, sck_gap = 0;
    int          cs_fall = 0, cs_rise = 0, cs_fall_cyc = 0, other_cs = 0;
    int          rx_cnt = 0;
    logic [15:0] rx_log [64];
    logic        sck_m = 1'b0, cs_m = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (sck !== sck_m) begin
            sck_tog++;
            sck_gap = cyc - sck_cyc;
            sck_cyc = cyc;
        end
        sck_m = sck;
        if (cs_n[2] !== cs_m) begin
            if (cs_n[2] == 1'b0) begin
                cs_fall++;
                cs_fall_cyc = cyc;
            end else cs_rise++;
        end
        cs_m = cs_n[2];
        if (cs_n[0] !== 1'b1 || cs_n[1] !== 1'b1 || cs_n[3] !== 1'b1) other_cs++;
        if (bus.rx_valid) begin
            rx_log[rx_cnt % 64] = bus.rx_data;
            rx_cnt++;
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        while (!bus.tx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb, input logic [7:0] div);
        cfg_cpol = pol;
        cfg_cpha = pha;
        cfg_lsb_first = lsb;
        cfg_div = div;
        repeat (3) @(negedge clk);
    endtask

    int s_rx, s_slv, s_tog, s_fall, s_rise, n;
    logic [3:0] m;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_clk_sck_cpol", 32'(sck), 32'd1);
        chk("first_clk_tx_ready", 32'(bus.tx_ready), 32'd1);

        // MODE0 MSB-first loopback, div=1: 32 SCK edges, last edge 64 clk after CS falls
        set_mode(1'b0, 1'b0, 1'b0, 8'd1);
        s_rx = rx_cnt; s_tog = sck_tog;
        send(16'hA55A, 1'b1);
        wait_idle();
        chk("lb_rx_count", 32'(rx_cnt - s_rx), 32'd1);
        chk("lb_rx_data", 32'(rx_log[(rx_cnt - 1) % 64]), 32'hA55A);
        chk("lb_sck_edges", 32'(sck_tog - s_tog), 32'd32);
        chk("lb_cs_to_last_edge", 32'(sck_cyc - cs_fall_cyc), 32'd64);

        // All four modes against the slave model
        loopback = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m = 4'(i);
            set_mode(m[1], m[0], 1'b0, 8'd1);
            s_rx = rx_cnt; s_slv = slv_cnt;
            send(16'h5A3C, 1'b1);
            wait_idle();
            chk($sformatf("mode%0d_rx_count", i), 32'(rx_cnt - s_rx), 32'd1);
            chk($sformatf("mode%0d_rx_data", i), 32'(rx_log[(rx_cnt - 1) % 64]), 32'h1234);
            chk($sformatf("mode%0d_slave_word", i), 32'(slv_log[(slv_cnt - 1) % 64]), 32'h5A3C);
            chk($sformatf("mode%0d_sck_idle", i), 32'(sck), 32'(m[1]));
        end

        // LSB-first: 0x0001 leaves as 1 then zeros; rx is the bit reverse of 0x1234
        set_mode(1'b0, 1'b0, 1'b1, 8'd1);
        s_rx = rx_cnt; s_slv = slv_cnt;
        send(16'h0001, 1'b1);
        chk("lsb_first_mosi_bit", 32'(mosi), 32'd1);
        wait_idle();
        chk("lsb_slave_word", 32'(slv_log[(slv_cnt - 1) % 64]), 32'h8000);
        chk("lsb_rx_data", 32'(rx_log[(rx_cnt - 1) % 64]), 32'h2C48);

        // Burst of three words with a 20-cycle stall in GAP before word 2
        set_mode(1'b0, 1'b0, 1'b0, 8'd1);
        s_rx = rx_cnt; s_slv = slv_cnt; s_fall = cs_fall; s_rise = cs_rise;
        send(16'h1111, 1'b0);
        n = 0;
        while (!bus.tx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("gap_cs_low", 32'(cs_n[2]), 32'd0);
        chk("gap_sck_idle", 32'(sck), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b1);
        wait_idle();
        chk("burst_cs_falls", 32'(cs_fall - s_fall), 32'd1);
        chk("burst_cs_rises", 32'(cs_rise - s_rise), 32'd1);
        chk("burst_rx_count", 32'(rx_cnt - s_rx), 32'd3);
        chk("burst_rx_w3", 32'(rx_log[(rx_cnt - 1) % 64]), 32'h1234);
        chk("burst_slave_w1", 32'(slv_log[s_slv % 64]), 32'h1111);
        chk("burst_slave_w2", 32'(slv_log[(s_slv + 1) % 64]), 32'h2222);
        chk("burst_slave_w3", 32'(slv_log[(s_slv + 2) % 64]), 32'h3333);

        // cfg_div change mid-burst only takes effect on the next CS assertion
        send(16'hAAAA, 1'b0);
        cfg_div = 8'd5;
        send(16'h5555, 1'b1);
        wait_idle();
        chk("div_midburst_halfperiod", 32'(sck_gap), 32'd2);
        send(16'h0F0F, 1'b1);
        wait_idle();
        chk("div_new_halfperiod", 32'(sck_gap), 32'd6);

        // Reset mid-transfer in MODE2 after 5 bits
        set_mode(1'b1, 1'b0, 1'b0, 8'd1);
        s_rx = rx_cnt; s_tog = sck_tog;
        send(16'hC000, 1'b1);
        n = 0;
        while ((sck_tog - s_tog) < 10 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached_5_bits", 32'(sck_tog - s_tog), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(cs_n), 32'hF);
        chk("midrst_sck", 32'(sck), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_rx_valid", 32'(rx_cnt - s_rx), 32'd0);
        chk("midrst_sck_cpol", 32'(sck), 32'd1);
        s_slv = slv_cnt;
        send(16'h0F0F, 1'b1);
        wait_idle();
        chk("postrst_rx_count", 32'(rx_cnt - s_rx), 32'd1);
        chk("postrst_rx_data", 32'(rx_log[(rx_cnt - 1) % 64]), 32'h1234);
        chk("postrst_slave_word", 32'(slv_log[(slv_cnt - 1) % 64]), 32'h0F0F);
        chk("postrst_slave_count", 32'(slv_cnt - s_slv), 32'd1);

        chk("other_cs_untouched", 32'(other_cs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
